// File: rtl/mem_access_unit_if.sv
// Request/response handshake and data-side memory port of the load/store unit.
// master is the requester/memory side; slave is the unit itself.
interface mem_access_unit_if #(
   parameter int N = 32,
   parameter int M = 10
);
   logic         req_valid;
   logic         req_ready;
   logic         req_we;
   logic [1:0]   req_size;
   logic         req_signed;
   logic [M+1:0] req_addr;
   logic [N-1:0] req_wdata;

   logic         resp_valid;
   logic         resp_ready;
   logic [N-1:0] resp_data;
   logic         resp_err;

   logic [M+1:0] mem_address;
   logic [N-1:0] mem_mask;
   logic         mem_wf;
   logic [N-1:0] mem_w;
   logic [N-1:0] mem_v;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output resp_ready, mem_v,
      input  req_ready, resp_valid, resp_data, resp_err,
      input  mem_address, mem_mask, mem_wf, mem_w
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  resp_ready, mem_v,
      output req_ready, resp_valid, resp_data, resp_err,
      output mem_address, mem_mask, mem_wf, mem_w
   );
endinterface

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for a big-endian memory with a
// one-cycle synchronous read; all outputs come straight from flops.
module mem_access_unit #(
   parameter int N = 32,
   parameter int M = 10
) (
   input logic             clk,
   input logic             rst,
   mem_access_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, LOAD_WAIT, RESP} state_t;

   state_t       state_q, state_d;
   logic         we_q, we_d;
   logic [1:0]   size_q, size_d;
   logic         signed_q, signed_d;
   logic         req_ready_q, req_ready_d;
   logic         resp_valid_q, resp_valid_d;
   logic [N-1:0] resp_data_q, resp_data_d;
   logic         resp_err_q, resp_err_d;
   logic [M+1:0] mem_address_q, mem_address_d;
   logic [N-1:0] mem_mask_q, mem_mask_d;
   logic         mem_wf_q, mem_wf_d;
   logic [N-1:0] mem_w_q, mem_w_d;

   // The byte at the access address lives in the top lane of the word.
   function automatic logic [N-1:0] place_wdata(input logic [1:0] size,
                                                input logic [N-1:0] wdata);
      case (size)
         2'b00:   return {wdata[7:0], {(N-8){1'b0}}};
         2'b01:   return {wdata[15:0], {(N-16){1'b0}}};
         default: return wdata;
      endcase
   endfunction

   function automatic logic [N-1:0] lane_mask(input logic [1:0] size);
      case (size)
         2'b00:   return {{8{1'b1}}, {(N-8){1'b0}}};
         2'b01:   return {{16{1'b1}}, {(N-16){1'b0}}};
         default: return {N{1'b1}};
      endcase
   endfunction

   function automatic logic [N-1:0] extract_load(input logic [1:0] size,
                                                 input logic sgn,
                                                 input logic [N-1:0] v);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      b = v[N-1 -: 8];
      h = v[N-1 -: 16];
      case (size)
         2'b00:   return {{(N-8){sgn & b[7]}}, b};
         2'b01:   return {{(N-16){sgn & h[15]}}, h};
         default: return v;
      endcase
   endfunction

   always_comb begin
      state_d       = state_q;
      we_d          = we_q;
      size_d        = size_q;
      signed_d      = signed_q;
      resp_data_d   = resp_data_q;
      resp_err_d    = resp_err_q;
      mem_address_d = mem_address_q;
      mem_w_d       = mem_w_q;
      mem_mask_d    = '0;
      mem_wf_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               we_d     = bus.req_we;
               size_d   = bus.req_size;
               signed_d = bus.req_signed;
               if (bus.req_size == 2'b11) begin
                  state_d     = RESP;
                  resp_data_d = '0;
                  resp_err_d  = 1'b1;
               end else begin
                  // Mask/strobe are only ever non-zero for the single ACCESS cycle.
                  state_d       = ACCESS;
                  mem_address_d = bus.req_addr;
                  mem_w_d       = place_wdata(bus.req_size, bus.req_wdata);
                  mem_mask_d    = lane_mask(bus.req_size);
                  mem_wf_d      = bus.req_we;
               end
            end
         end
         ACCESS: begin
            if (we_q) begin
               state_d     = RESP;
               resp_data_d = '0;
               resp_err_d  = 1'b0;
            end else begin
               state_d = LOAD_WAIT;
            end
         end
         LOAD_WAIT: begin
            state_d     = RESP;
            resp_data_d = extract_load(size_q, signed_q, bus.mem_v);
            resp_err_d  = 1'b0;
         end
         RESP: begin
            if (bus.resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      req_ready_d  = (state_d == IDLE);
      resp_valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         we_q          <= 1'b0;
         size_q        <= 2'b00;
         signed_q      <= 1'b0;
         req_ready_q   <= 1'b1;
         resp_valid_q  <= 1'b0;
         resp_data_q   <= '0;
         resp_err_q    <= 1'b0;
         mem_address_q <= '0;
         mem_mask_q    <= '0;
         mem_wf_q      <= 1'b0;
         mem_w_q       <= '0;
      end else begin
         state_q       <= state_d;
         we_q          <= we_d;
         size_q        <= size_d;
         signed_q      <= signed_d;
         req_ready_q   <= req_ready_d;
         resp_valid_q  <= resp_valid_d;
         resp_data_q   <= resp_data_d;
         resp_err_q    <= resp_err_d;
         mem_address_q <= mem_address_d;
         mem_mask_q    <= mem_mask_d;
         mem_wf_q      <= mem_wf_d;
         mem_w_q       <= mem_w_d;
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_data   = resp_data_q;
   assign bus.resp_err    = resp_err_q;
   assign bus.mem_address = mem_address_q;
   assign bus.mem_mask    = mem_mask_q;
   assign bus.mem_wf      = mem_wf_q;
   assign bus.mem_w       = mem_w_q;

endmodule
